// File: rtl/pwm_seq.sv
// Bus initiator that programs, verifies, holds and then disables one channel
// of the 8-channel PWM register block for each accepted command.
module pwm_seq #(
  parameter int HOLD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [31:0]       cmd_period,
  input  logic [31:0]       cmd_duty,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [7:0]        addr,
  output logic              wr,
  output logic              rd,
  output logic [31:0]       d_out,
  input  logic [31:0]       d_in,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WR_T  | write period to base+4
  // WR_D  | write duty to base+8
  // WR_E1 | write enable=1 to base
  // RD_E  | read enable back from base
  // CHK   | judge read-back, load hold counter
  // HOLD  | channel running, counting down
  // WR_E0 | write enable=0 to base
  // DONE  | one-cycle done pulse with err
  typedef enum logic [3:0] {
    S_IDLE, S_WR_T, S_WR_D, S_WR_E1, S_RD_E, S_CHK, S_HOLD, S_WR_E0, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        ch_q;
  logic [31:0]       duty_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] cnt;
  logic              chk_ok;
  logic [7:0]        base;

  wire unused_d_in = ^d_in[31:1];

  function automatic logic [7:0] base_of(input logic [2:0] ch);
    return ({5'd0, ch} << 3) + ({5'd0, ch} << 2);
  endfunction

  assign base = base_of(ch_q);

  // Bus outputs are registered together with the state, so every transition
  // into a bus state also loads that state's addr/wr/rd/d_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      addr      <= 8'd0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      d_out     <= 32'd0;
      ch_q      <= 3'd0;
      duty_q    <= 32'd0;
      hold_q    <= '0;
      cnt       <= '0;
      chk_ok    <= 1'b0;
    end else begin
      addr  <= 8'd0;
      wr    <= 1'b0;
      rd    <= 1'b0;
      d_out <= 32'd0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            ch_q      <= cmd_ch;
            duty_q    <= cmd_duty;
            hold_q    <= cmd_hold;
            if (cmd_period == 32'd0 || cmd_duty > cmd_period) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              err   <= 1'b0;
              state <= S_WR_T;
              wr    <= 1'b1;
              addr  <= base_of(cmd_ch) + 8'd4;
              d_out <= cmd_period;
            end
          end
        end
        S_WR_T: begin
          state <= S_WR_D;
          wr    <= 1'b1;
          addr  <= base + 8'd8;
          d_out <= duty_q;
        end
        S_WR_D: begin
          state <= S_WR_E1;
          wr    <= 1'b1;
          addr  <= base;
          d_out <= 32'd1;
        end
        S_WR_E1: begin
          state <= S_RD_E;
          rd    <= 1'b1;
          addr  <= base;
        end
        S_RD_E: begin
          chk_ok <= d_in[0];
          state  <= S_CHK;
        end
        S_CHK: begin
          if (!chk_ok || hold_q == '0) begin
            if (!chk_ok) err <= 1'b1;
            state <= S_WR_E0;
            wr    <= 1'b1;
            addr  <= base;
          end else begin
            cnt   <= hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort || cnt == '0) begin
            state <= S_WR_E0;
            wr    <= 1'b1;
            addr  <= base;
          end else begin
            cnt <= cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        S_WR_E0: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_seq.sv
// Bench for pwm_seq: slave register model, per-cycle bus trace reference,
// table vectors, randomized commands and a reset-during-hold sequence.
module tb_pwm_seq;
  localparam int HOLD_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_ch = 3'd0;
  logic [31:0]       cmd_period = 32'd0;
  logic [31:0]       cmd_duty = 32'd0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic              abort = 1'b0;
  logic [7:0]        addr;
  logic              wr;
  logic              rd;
  logic [31:0]       d_out;
  logic [31:0]       d_in;
  logic              done;
  logic              err;
  logic              force_bad = 1'b0;
  logic [31:0]       mem [0:255];
  int                n_total = 0;
  int                n_bad = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [31:0] data;
    logic       done;
    logic       err;
    logic       ready;
  } cyc_t;

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] t;
    logic [31:0] d;
    int          h;
    bit          bad;
    int          ab;
    int          done_edge;
    int          exp_err;
  } vec_t;

  pwm_seq #(.HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_period(cmd_period), .cmd_duty(cmd_duty),
    .cmd_hold(cmd_hold), .abort(abort), .addr(addr), .wr(wr), .rd(rd),
    .d_out(d_out), .d_in(d_in), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // PWM register slave: samples on negedge, has no reset
  always @(negedge clk) if (wr) mem[addr] <= d_out;
  assign d_in = force_bad ? 32'd0 : (rd ? mem[addr] : 32'd0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cyc_t mk(logic w, logic r, logic [7:0] a, logic [31:0] dt,
                              logic dn, logic e, logic rdy);
    cyc_t c;
    c.wr = w; c.rd = r; c.addr = a; c.data = dt; c.done = dn; c.err = e; c.ready = rdy;
    return c;
  endfunction

  task automatic run_cmd(input vec_t v, input string nm);
    cyc_t expq[$];
    cyc_t e;
    logic [7:0] b;
    int hold_n;
    int done_at;
    int guard;
    logic err_seen;
    bit ok;
    bit rejected;
    done_at = -1;
    guard = 0;
    err_seen = 1'b0;
    b = 8'(int'(v.ch) * 12);
    rejected = (v.t == 32'd0) || (v.d > v.t);
    if (rejected) begin
      expq.push_back(mk(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b1, 1'b0));
    end else begin
      hold_n = v.bad ? 0 : ((v.ab != 0 && v.ab <= v.h) ? v.ab : v.h);
      expq.push_back(mk(1'b1, 1'b0, b + 8'd4, v.t, 1'b0, 1'b0, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, b + 8'd8, v.d, 1'b0, 1'b0, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, b, 32'd1, 1'b0, 1'b0, 1'b0));
      expq.push_back(mk(1'b0, 1'b1, b, 32'd0, 1'b0, 1'b0, 1'b0));
      repeat (hold_n + 1) expq.push_back(mk(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      expq.push_back(mk(1'b1, 1'b0, b, 32'd0, 1'b0, 1'b0, 1'b0));
      expq.push_back(mk(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, v.bad, 1'b0));
    end
    expq.push_back(mk(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1));

    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_total++; n_bad++;
      $display("FAIL %s ready_timeout: cmd_ready=%b required 1", nm, cmd_ready);
      return;
    end
    force_bad  = v.bad;
    cmd_ch     = v.ch;
    cmd_period = v.t;
    cmd_duty   = v.d;
    cmd_hold   = HOLD_W'(v.h);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= expq.size(); i++) begin
      @(negedge clk);
      e = expq[i-1];
      ok = (wr === e.wr) && (rd === e.rd) && (addr === e.addr) && (d_out === e.data) &&
           (done === e.done) && (cmd_ready === e.ready) && (!e.done || err === e.err);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got wr=%b rd=%b addr=%h d=%h done=%b err=%b rdy=%b required wr=%b rd=%b addr=%h d=%h done=%b err=%b rdy=%b",
                 nm, i, wr, rd, addr, d_out, done, err, cmd_ready,
                 e.wr, e.rd, e.addr, e.data, e.done, e.err, e.ready);
      end
      if (done === 1'b1 && done_at < 0) begin
        done_at = i - 1;
        err_seen = err;
      end
      abort = (v.ab != 0 && i == 5 + v.ab);
    end
    abort = 1'b0;
    force_bad = 1'b0;
    if (v.done_edge >= 0) begin
      n_total++;
      if (done_at != v.done_edge || err_seen !== 1'(v.exp_err)) begin
        n_bad++;
        $display("FAIL %s done_timing: done at k+%0d err=%b required k+%0d err=%0d",
                 nm, done_at, err_seen, v.done_edge, v.exp_err);
      end
    end
    if (!rejected) begin
      n_total++;
      if (mem[b] !== 32'd0 || mem[b+8'd4] !== v.t || mem[b+8'd8] !== v.d) begin
        n_bad++;
        $display("FAIL %s slave_regs: E=%h T=%h D=%h required E=0 T=%h D=%h",
                 nm, mem[b], mem[b+8'd4], mem[b+8'd8], v.t, v.d);
      end
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    n_total++;
    if (addr !== 8'd0 || wr !== 1'b0 || rd !== 1'b0 || d_out !== 32'd0 ||
        done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: addr=%h wr=%b rd=%b d=%h done=%b err=%b rdy=%b required all 0 with rdy=1",
               nm, addr, wr, rd, d_out, done, err, cmd_ready);
    end
  endtask

  vec_t tab [8];
  vec_t v;

  initial begin
    tab[0] = '{3'd2, 32'd1000, 32'd250, 3, 1'b0, 0, 9, 0};
    tab[1] = '{3'd7, 32'd5, 32'd5, 0, 1'b0, 0, 6, 0};
    tab[2] = '{3'd1, 32'd1000, 32'd1001, 4, 1'b0, 0, 0, 1};
    tab[3] = '{3'd3, 32'd0, 32'd0, 4, 1'b0, 0, 0, 1};
    tab[4] = '{3'd4, 32'd10, 32'd0, 2, 1'b1, 0, 6, 1};
    tab[5] = '{3'd5, 32'd100, 32'd50, 100, 1'b0, 5, 11, 0};
    tab[6] = '{3'd0, 32'd1, 32'd1, 1, 1'b0, 0, 7, 0};
    tab[7] = '{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 0, 8, 0};
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_release");

    for (int i = 0; i < 8; i++) run_cmd(tab[i], $sformatf("vec%0d", i));

    // reset asserted while the channel is in HOLD
    @(negedge clk);
    cmd_ch = 3'd3; cmd_period = 32'd50; cmd_duty = 32'd20; cmd_hold = HOLD_W'(20);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("reset_in_hold");
    n_total++;
    if (mem[36] !== 32'd1) begin
      n_bad++;
      $display("FAIL reset_in_hold_enable: E=%h required 1", mem[36]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{3'd3, 32'd50, 32'd20, 2, 1'b0, 0, 8, 0};
    run_cmd(v, "after_reset");

    for (int n = 0; n < 40; n++) begin
      v.ch = 3'($urandom_range(0, 7));
      v.t = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 20);
      if ($urandom % 6 == 0) v.d = v.t + 32'd1;
      else v.d = (v.t == 32'd0) ? 32'd0 : $urandom_range(0, v.t);
      v.h = $urandom_range(0, 12);
      v.bad = ($urandom % 5 == 0);
      v.ab = ($urandom % 3 == 0) ? $urandom_range(1, 14) : 0;
      v.done_edge = -1;
      v.exp_err = 0;
      run_cmd(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
